clock_period_meter: RTL and testbench

Measures the half-period of a slow square wave, such as the divided clock produced by the design's clock divider, in cycles of the system clock `clk`. It reports the result in divider-ratio form: `div_out = half_period_cycles - 1`. A divider programmed with `div = D` therefore reads back as `D` when looped into this block. The block sits on the receive side of the blink/clock path and is used for self-check of divider settings and for measuring external slow clocks.

---
 rtl/clock_period_meter.sv | 142 ++++++++++++++
 tb/tb_clock_period_meter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// Measures the half-period of a slow square wave in clk cycles and reports it as half_period-1.
// Optional loss-of-signal timeout is built when CLOCK_PERIOD_METER_TIMEOUT_EN is defined.
module clock_period_meter #(
  parameter int unsigned WIDTH = 24
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 24'hFFFFFF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] div_out,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_TRACK = 2'd2;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             dly_q, dly_d;
  logic             edge_q, edge_d;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             ovf_q, ovf_d;
  logic             ovf_hit_c;

`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
  localparam int unsigned TO_W = 32;
  logic [TO_W-1:0]  to_q, to_d;
  logic             to_fire_c;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dly_q    <= 1'b0;
      edge_q   <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      dly_q    <= dly_d;
      edge_q   <= edge_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  // Next-state logic: synchronizer, edge pipeline, interval counter and measurement FSM
  always_comb begin
    sync1_d  = sig_in;
    sync2_d  = sync1_q;
    dly_d    = sync2_q;
    edge_d   = sync2_q ^ dly_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    ovf_d    = ovf_q;
    // A saturated count on the edge cycle is treated as overflow even if the flag lags
    ovf_hit_c = ovf_q || (cnt_q == CNT_MAX);

`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
    to_fire_c = !edge_q && (to_q == TO_W'(TIMEOUT - 1));
    if (edge_q) begin
      to_d = '0;
    end else if (to_q == TO_W'(TIMEOUT)) begin
      to_d = to_q;
    end else begin
      to_d = to_q + TO_W'(1);
    end
`endif

    if (edge_q) begin
      cnt_d = '0;
      ovf_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          state_d = S_ARMED;
        end
        default: begin
          if (ovf_hit_c) begin
            state_d  = S_ARMED;
            locked_d = 1'b0;
          end else begin
            div_d    = cnt_q;
            valid_d  = 1'b1;
            locked_d = (cnt_q == div_q) && (state_q == S_TRACK);
            state_d  = S_TRACK;
          end
        end
      endcase
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      if (cnt_q == CNT_MAX - WIDTH'(1)) begin
        ovf_d = 1'b1;
      end
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
      if (to_fire_c) begin
        state_d  = S_IDLE;
        locked_d = 1'b0;
        ovf_d    = 1'b0;
      end
`endif
    end
  end

  assign div_out  = div_q;
  assign valid    = valid_q;
  assign locked   = locked_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomized and directed bench for clock_period_meter against an event-based interval model.
// Honours CLOCK_PERIOD_METER_TIMEOUT_EN (TIMEOUT = 50) when defined.
module tb_clock_period_meter;

  localparam int unsigned WIDTH = 4;
  localparam int MAXC = (1 << WIDTH) - 1;
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
  localparam int TIMEOUT = 50;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_TRACK = 2;

  logic             clk;
  logic             rst;
  logic             sig_in;
  logic [WIDTH-1:0] div_out;
  logic             valid;
  logic             locked;
  logic             overflow;

  clock_period_meter #(
    .WIDTH(WIDTH)
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .div_out  (div_out),
    .valid    (valid),
    .locked   (locked),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: edges become events 3 cycles after sampling; measurements from event spacing
  int cyc = 0;
  int last_e = 0;
  int mstate = M_IDLE;
  int mdiv = 0;
  bit mlock = 1'b0;
  bit mvalid = 1'b0;
  bit prev_s = 1'b0;
  int evq[$];
  bit cur_s = 1'b0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit ovf_at(input int d);
    bit o;
    o = (d >= MAXC);
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
    if (TIMEOUT >= MAXC && d >= TIMEOUT) o = 1'b0;
`endif
    return o;
  endfunction

  task automatic model_step(input bit r, input bit s);
    bit ev;
    int g;
    cyc++;
    if (r) begin
      mstate = M_IDLE;
      mdiv   = 0;
      mlock  = 1'b0;
      mvalid = 1'b0;
      last_e = cyc;
      prev_s = 1'b0;
      evq.delete();
      return;
    end
    mvalid = 1'b0;
    if (s != prev_s) evq.push_back(cyc + 3);
    prev_s = s;
    ev = 1'b0;
    if (evq.size() > 0 && evq[0] == cyc) begin
      ev = 1'b1;
      void'(evq.pop_front());
    end
    if (ev) begin
      g = cyc - last_e;
      if (mstate == M_IDLE) begin
        mstate = M_ARMED;
      end else if (ovf_at(g - 1)) begin
        mstate = M_ARMED;
        mlock  = 1'b0;
      end else begin
        mlock  = (mstate == M_TRACK) && (g - 1 == mdiv);
        mdiv   = g - 1;
        mvalid = 1'b1;
        mstate = M_TRACK;
      end
      last_e = cyc;
    end else begin
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
      if (cyc - last_e == TIMEOUT) begin
        mstate = M_IDLE;
        mlock  = 1'b0;
      end
`endif
    end
  endtask

  task automatic step(input bit r, input bit s);
    rst    = r;
    sig_in = s;
    @(posedge clk);
    #1;
    model_step(r, s);
    check("valid", 32'(valid), 32'(mvalid));
    check("div_out", 32'(div_out), 32'(mdiv));
    check("locked", 32'(locked), 32'(mlock));
    check("overflow", 32'(overflow), 32'(ovf_at(cyc - last_e)));
  endtask

  task automatic half(input int n);
    cur_s = ~cur_s;
    repeat (n) step(1'b0, cur_s);
  endtask

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    check("rst_div", 32'(div_out), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_ovf", 32'(overflow), 0);

    // Divider loopback, div = 5
    repeat (12) half(6);
    check("loop_div", 32'(div_out), 5);
    check("loop_locked", 32'(locked), 1);

    // Ratio change to div = 9
    repeat (8) half(10);
    check("ratio_div", 32'(div_out), 9);
    check("ratio_locked", 32'(locked), 1);

    // Minimum interval
    repeat (20) half(1);
    check("min_div", 32'(div_out), 0);
    check("min_valid", 32'(valid), 1);
    check("min_locked", 32'(locked), 1);

    // Overflow: hold for 20 cycles, then two 6-cycle intervals
    repeat (20) step(1'b0, cur_s);
    check("ovf_set", 32'(overflow), 1);
    half(6);
    check("ovf_clr", 32'(overflow), 0);
    half(6);
    check("ovf_next_div", 32'(div_out), 5);

    // Reset mid-interval
    half(6);
    half(6);
    repeat (3) step(1'b0, cur_s);
    step(1'b1, cur_s);
    check("midrst_div", 32'(div_out), 0);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_valid", 32'(valid), 0);
    repeat (3) step(1'b0, cur_s);
    repeat (6) half(6);

`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
    // Loss of signal while locked at 5
    repeat (60) step(1'b0, cur_s);
    check("to_locked", 32'(locked), 0);
    check("to_div", 32'(div_out), 5);
    half(6);
    half(6);
`endif

    // Randomized half-periods with occasional resets
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 49) == 0) step(1'b1, cur_s);
      half(int'($urandom_range(1, 20)));
    end
    repeat (40) step(1'b0, cur_s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
